multi_hot_grant_sequencer: RTL and testbench
============================================

Name: multi_hot_grant_sequencer

Overview:
- Registered successor to the combinational multi-hot to one-hot converter.
- Accepts multi-hot channel request pulses (e.g. per-channel hit flags from the TDC front end) and stores them as sticky pending bits.
- Emits the pending bits one at a time as one-hot grant plus binary index, over a valid/ready handshake toward the readout logic.
- Supports two priority modes, fixed MSB-first and round-robin, and counts requests lost to collisions.

Parameters:
- WIDTH, 8, number of request channels (≥2).
- IDX_W, $clog2(WIDTH), width of out_index.
- CNT_W, 8, width of the saturating collision counter.

Ports:
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed priority (bit WIDTH-1 highest); 1 = round-robin.
- flush  in  1  synchronous clear of pending bits and the output stage.
- req_in  in  WIDTH  multi-hot request pulses; any number of bits per cycle.
- out_ready  in  1  consumer accepts the grant when high together with out_valid.
- out_valid  out  1  grant present.
- out_onehot  out  WIDTH  one-hot grant; all zero when out_valid=0.
- out_index  out  IDX_W  binary index of the granted bit.
- busy  out  1  high when any pending bit is set or out_valid=1.
- collision_cnt  out  CNT_W  saturating count of collision events.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_onehot=0, out_index=0, pending=0, ptr=WIDTH-1, collision_cnt=0, busy=0.
- Candidate set C = pending | req_in. Same-cycle requests are eligible, so latency is 1 cycle: a request at edge N produces out_valid at edge N+1 when the output stage is free.
- Load condition L = (out_valid==0) | out_ready. When L is true and C≠0:
  - out_valid←1; out_onehot←selected bit; out_index←its index; ptr←its index.
  - The selected bit is cleared from pending. All other C bits are stored in pending.
- When L is true and C=0: out_valid←0, out_onehot←0, out_index holds its value.
- When L is false: out_* hold exactly; pending←pending | req_in.
- Selection order:
  - mode=0: WIDTH-1 down to 0. This is the same result as the combinational converter.
  - mode=1: ptr-1, ptr-2, …, 0, WIDTH-1, …, ptr (wrap-around). The last-granted channel has lowest priority.
  - mode is sampled at each load. Changing mode mid-stream only affects later selections. ptr updates in both modes.
- Collision: a req_in bit that is already set in pending, or that equals the grant currently held with L false. Each cycle with ≥1 such bit adds 1 to collision_cnt. The count is per cycle, not per bit, and saturates at 2^CNT_W-1.
- A request for the same channel as the grant being loaded this cycle is not a collision. It is consumed by that grant.
- flush=1 (priority over everything except reset):
  - Next edge: pending←0, out_valid←0, out_onehot←0.
  - req_in in that cycle is discarded.
  - ptr and collision_cnt are unchanged.
- busy is registered-equivalent: it is derived from pending and out_valid, not from req_in.
- Simultaneous events: acceptance (valid&ready) and a new load happen in the same cycle, with no bubble. This gives 1 grant per cycle throughput at sustained ready=1.
- Reset asserted mid-burst drops all pending work immediately. No grant is emitted after rst_n deasserts until a new req_in arrives.

Test Plan:
- WIDTH=8, mode=0, out_ready=1; pulse req_in=0111_0010 at edge N → grants idx 6,5,4,1 (onehot 0100_0000, 0010_0000, 0001_0000, 0000_0010) at N+1..N+4; out_valid=0 and busy=0 at N+5; collision_cnt=0.
- mode=0 vs mode=1, out_ready=1; pulse 1000_0001 at N, pulse 1000_0000 at N+1 → mode=0 gives idx 7,7,0 at N+1..N+3; mode=1 gives idx 7,0,7.
- out_ready=0; pulse 0000_1000 at N, again at N+2, then 0000_0100 at N+3 → idx 3 held stable from N+1 with out_onehot=0000_1000; collision_cnt=1; raise ready at N+5 → next grant is idx 2, then valid drops.
- Saturation with CNT_W=2, out_ready=0: hold req_in=0000_0001 for 6 cycles → collision_cnt reaches 3 and stays 3.
- flush=1 for one cycle with pending={5,2} and grant valid → next edge out_valid=0, busy=0, collision_cnt unchanged; a later pulse 0000_0100 in mode=1 with ptr=5 grants idx 2.
- Assert rst_n=0 asynchronously mid-burst (between edges) → all outputs 0 immediately; after release, no grants until new req_in.

Source files
------------

// File: rtl/multi_hot_grant_sequencer.sv
// Sticky multi-hot request collector that emits pending channels one at a time
// as a one-hot grant plus index over valid/ready, in fixed or round-robin order.
module multi_hot_grant_sequencer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             flush,
    input  logic [WIDTH-1:0] req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_index,
    output logic             busy,
    output logic [CNT_W-1:0] collision_cnt
);

    logic [WIDTH-1:0] pending;
    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] cand;
    logic             load;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [WIDTH-1:0] sel_oh;
    logic             coll_hit;

    assign cand = pending | req_in;
    assign load = ~out_valid | out_ready;

    // Later loop iterations override earlier ones, so each loop ends on the
    // highest-priority candidate: bit WIDTH-1 for fixed, ptr-1 for round-robin.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_idx    = '0;
        if (!mode) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cand[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = WIDTH; k >= 1; k--) begin
                rr_idx = IDX_W'((int'(ptr) - k + WIDTH) % WIDTH);
                if (cand[rr_idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = rr_idx;
                end
            end
        end
    end

    assign sel_oh = sel_found ? (WIDTH'(1) << sel_idx) : '0;

    // A request matching a grant that is still stalled is merged into it (lost),
    // which is why it counts as a collision and is not re-queued below.
    assign coll_hit = load ? |(req_in & pending & ~sel_oh)
                           : |(req_in & (pending | out_onehot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            ptr           <= IDX_W'(WIDTH - 1);
            out_valid     <= 1'b0;
            out_onehot    <= '0;
            out_index     <= '0;
            collision_cnt <= '0;
        end else if (flush) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
        end else begin
            if (load) begin
                pending    <= cand & ~sel_oh;
                out_valid  <= sel_found;
                out_onehot <= sel_oh;
                if (sel_found) begin
                    out_index <= sel_idx;
                    ptr       <= sel_idx;
                end
            end else begin
                pending <= pending | (req_in & ~out_onehot);
            end
            if (coll_hit && (collision_cnt != '1)) begin
                collision_cnt <= collision_cnt + 1'b1;
            end
        end
    end

    assign busy = (|pending) | out_valid;

endmodule

// File: tb/tb_multi_hot_grant_sequencer.sv
// Checks multi_hot_grant_sequencer against a behavioural model of its rules,
// using directed scenarios with literal expectations followed by random traffic.
module tb_multi_hot_grant_sequencer;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       flush;
    logic [7:0] req_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic [2:0] out_index;
    logic       busy;
    logic [7:0] collision_cnt;

    logic [7:0] req_s;
    logic       valid_s;
    logic [7:0] onehot_s;
    logic [2:0] index_s;
    logic       busy_s;
    logic [1:0] cnt_s;

    multi_hot_grant_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush), .req_in(req_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_onehot(out_onehot),
        .out_index(out_index), .busy(busy), .collision_cnt(collision_cnt)
    );

    multi_hot_grant_sequencer #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .flush(1'b0), .req_in(req_s),
        .out_ready(1'b0), .out_valid(valid_s), .out_onehot(onehot_s),
        .out_index(index_s), .busy(busy_s), .collision_cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model state
    bit [7:0] m_pend;
    bit [7:0] m_oh;
    bit       m_valid;
    int       m_idx;
    int       m_ptr;
    int       m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [7:0] c, input bit md, input int p);
        if (!md) begin
            for (int i = 7; i >= 0; i--) if (c[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int j;
                j = (p - k + 8) % 8;
                if (c[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_oh = '0; m_valid = 0; m_idx = 0; m_ptr = 7; m_cnt = 0;
    endtask

    task automatic model_step(input bit [7:0] req, input bit md, input bit fl, input bit rdy);
        bit       ld;
        bit       coll;
        int       s;
        bit [7:0] sb;
        if (fl) begin
            m_pend = '0; m_valid = 0; m_oh = '0;
            return;
        end
        ld = !m_valid || rdy;
        if (ld) begin
            s    = pick(m_pend | req, md, m_ptr);
            sb   = (s >= 0) ? (8'b1 << s) : 8'b0;
            coll = (req & m_pend & ~sb) != 0;
            if (s >= 0) begin
                m_valid = 1; m_oh = sb; m_idx = s; m_ptr = s;
            end else begin
                m_valid = 0; m_oh = '0;
            end
            m_pend = (m_pend | req) & ~sb;
        end else begin
            coll   = (req & (m_pend | m_oh)) != 0;
            m_pend = m_pend | (req & ~m_oh);
        end
        if (coll && m_cnt < 255) m_cnt++;
    endtask

    task automatic cyc(input logic [7:0] r, input logic md, input logic fl, input logic rdy);
        req_in = r; mode = md; flush = fl; out_ready = rdy;
        @(posedge clk);
        model_step(r, md, fl, rdy);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid", int'(out_valid), int'(m_valid));
            chk("cmp_onehot", int'(out_onehot), int'(m_oh));
            chk("cmp_busy", int'(busy), int'((m_pend != 0) || m_valid));
            chk("cmp_cnt", int'(collision_cnt), m_cnt);
            if (m_valid) chk("cmp_index", int'(out_index), m_idx);
        end
    end

    initial begin
        rst_n = 0; mode = 0; flush = 0; req_in = '0; out_ready = 0; req_s = '0;
        model_reset();
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_onehot", int'(out_onehot), 0);
        chk("rst_index", int'(out_index), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(collision_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1;
        chk_en = 1;

        // fixed-priority drain of a multi-hot pulse
        cyc(8'b0111_0010, 0, 0, 1);
        chk("t1_idx6", int'(out_index), 6); chk("t1_oh6", int'(out_onehot), 8'h40);
        cyc(8'h00, 0, 0, 1);
        chk("t1_idx5", int'(out_index), 5); chk("t1_oh5", int'(out_onehot), 8'h20);
        cyc(8'h00, 0, 0, 1);
        chk("t1_idx4", int'(out_index), 4); chk("t1_oh4", int'(out_onehot), 8'h10);
        cyc(8'h00, 0, 0, 1);
        chk("t1_idx1", int'(out_index), 1); chk("t1_oh1", int'(out_onehot), 8'h02);
        cyc(8'h00, 0, 0, 1);
        chk("t1_valid_end", int'(out_valid), 0);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_cnt", int'(collision_cnt), 0);

        // fixed vs round-robin order
        cyc(8'h81, 0, 0, 1); chk("t2f_a", int'(out_index), 7);
        cyc(8'h80, 0, 0, 1); chk("t2f_b", int'(out_index), 7);
        cyc(8'h00, 0, 0, 1); chk("t2f_c", int'(out_index), 0);
        cyc(8'h00, 0, 0, 1); chk("t2f_idle", int'(out_valid), 0);
        cyc(8'h01, 1, 0, 1); chk("t2r_ptr0", int'(out_index), 0);
        cyc(8'h00, 1, 0, 1);
        cyc(8'h81, 1, 0, 1); chk("t2r_a", int'(out_index), 7);
        cyc(8'h80, 1, 0, 1); chk("t2r_b", int'(out_index), 0);
        cyc(8'h00, 1, 0, 1); chk("t2r_c", int'(out_index), 7);
        cyc(8'h00, 1, 0, 1); chk("t2r_idle", int'(out_valid), 0);

        // backpressure, held grant, collision on the held channel
        cyc(8'h08, 0, 0, 0);
        chk("t3_idx", int'(out_index), 3); chk("t3_oh", int'(out_onehot), 8'h08);
        cyc(8'h00, 0, 0, 0);
        cyc(8'h08, 0, 0, 0);
        cyc(8'h04, 0, 0, 0);
        cyc(8'h00, 0, 0, 0);
        chk("t3_hold_oh", int'(out_onehot), 8'h08);
        chk("t3_cnt", int'(collision_cnt), 1);
        cyc(8'h00, 0, 0, 1); chk("t3_next", int'(out_index), 2);
        cyc(8'h00, 0, 0, 1); chk("t3_drop", int'(out_valid), 0);

        // flush with pending work; flush-cycle requests are discarded uncounted
        cyc(8'b1010_0100, 0, 0, 1); chk("t4_grant", int'(out_index), 7);
        cyc(8'h21, 0, 1, 1);
        chk("t4_valid", int'(out_valid), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_cnt", int'(collision_cnt), 1);
        cyc(8'h00, 0, 0, 1); chk("t4_after", int'(out_valid), 0);
        cyc(8'h20, 1, 0, 1); chk("t4_ptr5", int'(out_index), 5);
        cyc(8'h00, 1, 0, 1);
        cyc(8'h04, 1, 0, 1); chk("t4_rr2", int'(out_index), 2);
        cyc(8'h00, 1, 0, 1);

        // asynchronous reset mid-burst
        cyc(8'hFF, 0, 0, 1); chk("t5_b0", int'(out_index), 7);
        cyc(8'h00, 0, 0, 1); chk("t5_b1", int'(out_index), 6);
        req_in = '0; mode = 0; flush = 0; out_ready = 1;
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_onehot", int'(out_onehot), 0);
        chk("t5_index", int'(out_index), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_cnt", int'(collision_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 0, 0, 1);
            chk("t5_noglitch", int'(out_valid), 0);
        end
        cyc(8'h81, 1, 0, 1); chk("t5_ptr_rst", int'(out_index), 0);
        cyc(8'h00, 1, 0, 1); chk("t5_rr7", int'(out_index), 7);
        cyc(8'h00, 1, 0, 1);

        // 2-bit counter saturation on the second instance
        req_s = 8'h01;
        for (int i = 0; i < 6; i++) begin
            cyc(8'h00, 0, 0, 1);
            chk("t6_sat", int'(cnt_s), (i < 3) ? i : 3);
        end
        chk("t6_idx", int'(index_s), 0);
        req_s = 8'h00;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic       md;
            r  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
            md = (i / 50) % 2 == 1;
            if ($urandom_range(0, 9) == 0) md = ~md;
            cyc(r, md, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++) cyc(8'h00, 0, 0, 1);
        chk("end_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
